// File: rtl/uart2wifi_core_tx_sched.sv
// uart2wifi_core_tx_sched
//   Shares the single UART transmitter between two first-word-fall-through
//   byte FIFOs (source 0: command/response, source 1: RX loopback).
//   Round-robin arbitration with a per-source burst limit. Each byte goes
//   IDLE -> POP -> WR -> WAIT, with an optional baud-tick guard before the
//   next byte is started.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   enable                when low no new byte is started
//   baudtick              one-cycle pulse from the baud generator
//   srcN_empty/rdata/rd   FIFO empty flag, head byte, pop strobe (N = 0, 1)
//   tx_wr, tx_data        one-cycle write strobe and byte to the UART
//   tx_done               one-cycle end-of-frame pulse from the UART
//   grant                 one-hot owner of the byte in flight, 00 when idle
//   busy                  high in any state other than IDLE
//   cnt0, cnt1            wrapping count of bytes popped from each source
module uart2wifi_core_tx_sched #(
    parameter int BURST_MAX   = 4,
    parameter int GUARD_TICKS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        baudtick,
    input  logic        src0_empty,
    input  logic [7:0]  src0_rdata,
    output logic        src0_rd,
    input  logic        src1_empty,
    input  logic [7:0]  src1_rdata,
    output logic        src1_rd,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_TICKS - 1);

    typedef enum logic [2:0] {IDLE, POP, WR, WAIT, GUARD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       owner;       // current / last owner: 0 = source 0, 1 = source 1
    logic [3:0] burst_cnt;
    logic [7:0] guard_cnt;

    logic       own_ne;
    logic       oth_ne;
    logic       sel_nxt;
    logic [3:0] burst_nxt;
    logic       start;

    // Arbitration. burst_cnt == 0 only after reset and means "no history",
    // so the preference-to-keep rule is skipped and source 0 wins a tie
    // because owner resets to source 1.
    always_comb begin
        own_ne    = owner ? !src1_empty : !src0_empty;
        oth_ne    = owner ? !src0_empty : !src1_empty;
        sel_nxt   = owner;
        burst_nxt = burst_cnt;
        if (own_ne && (burst_cnt != 4'd0) && (burst_cnt < BURST_LIM)) begin
            burst_nxt = burst_cnt + 4'd1;
        end else if (oth_ne) begin
            sel_nxt   = ~owner;
            burst_nxt = 4'd1;
        end else if (burst_cnt < BURST_LIM) begin
            burst_nxt = burst_cnt + 4'd1;
        end
    end

    assign start = (state == IDLE) && enable && (!src0_empty || !src1_empty);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; tx_done is honoured in WR as well as WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = POP;
            POP:   state_nxt = WR;
            WR, WAIT: begin
                if (tx_done) begin
                    state_nxt = (GUARD_TICKS > 0) ? GUARD : IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            GUARD: if (baudtick && (guard_cnt == GUARD_LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        src0_rd = (state == POP) && !owner;
        src1_rd = (state == POP) && owner;
        tx_wr   = (state == WR);
        busy    = (state != IDLE);
        grant   = 2'b00;
        if (state != IDLE) begin
            grant = owner ? 2'b10 : 2'b01;
        end
    end

    // Arbitration history, byte capture, counters and guard counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b1;
            burst_cnt <= 4'd0;
            tx_data   <= 8'h00;
            cnt0      <= 16'h0000;
            cnt1      <= 16'h0000;
            guard_cnt <= 8'h00;
        end else begin
            if (start) begin
                owner     <= sel_nxt;
                burst_cnt <= burst_nxt;
            end
            if (state == POP) begin
                if (owner) begin
                    tx_data <= src1_rdata;
                    cnt1    <= cnt1 + 16'd1;
                end else begin
                    tx_data <= src0_rdata;
                    cnt0    <= cnt0 + 16'd1;
                end
            end
            // A baudtick coinciding with tx_done arrives in WR/WAIT and is
            // therefore never counted here.
            if ((state == GUARD) && baudtick) begin
                if (guard_cnt == GUARD_LAST) begin
                    guard_cnt <= 8'h00;
                end else begin
                    guard_cnt <= guard_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart2wifi_core_tx_sched.sv
// Testbench for uart2wifi_core_tx_sched. Main instance uses the default
// parameters (BURST_MAX=4, GUARD_TICKS=0); a second instance with
// GUARD_TICKS=3 covers the guard interval. Bytes written to the UART are
// checked by a scoreboard monitor against hand-computed expected order.
module tb_uart2wifi_core_tx_sched;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        baudtick;
    logic        src0_empty;
    logic [7:0]  src0_rdata;
    logic        src0_rd;
    logic        src1_empty;
    logic [7:0]  src1_rdata;
    logic        src1_rd;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    logic        g_enable;
    logic        g_src0_rd;
    logic        g_src1_rd;
    logic        g_tx_wr;
    logic [7:0]  g_tx_data;
    logic        g_tx_done;
    logic [1:0]  g_grant;
    logic        g_busy;
    logic [15:0] g_cnt0;
    logic [15:0] g_cnt1;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [9:0]  exp_q[$];
    logic [7:0]  ord [20];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ucnt    = 0;
    int last_done = -1;
    bit gap_chk = 0;

    uart2wifi_core_tx_sched #(.BURST_MAX(4), .GUARD_TICKS(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .baudtick(baudtick),
        .src0_empty(src0_empty), .src0_rdata(src0_rdata), .src0_rd(src0_rd),
        .src1_empty(src1_empty), .src1_rdata(src1_rdata), .src1_rd(src1_rd),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_done(tx_done),
        .grant(grant), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    // Guard instance: source 0 is an endless stream of 0x5A, source 1 empty
    uart2wifi_core_tx_sched #(.BURST_MAX(4), .GUARD_TICKS(3)) u_guard (
        .clk(clk), .rst_n(rst_n), .enable(g_enable), .baudtick(baudtick),
        .src0_empty(1'b0), .src0_rdata(8'h5A), .src0_rd(g_src0_rd),
        .src1_empty(1'b1), .src1_rdata(8'h00), .src1_rd(g_src1_rd),
        .tx_wr(g_tx_wr), .tx_data(g_tx_data), .tx_done(g_tx_done),
        .grant(g_grant), .busy(g_busy), .cnt0(g_cnt0), .cnt1(g_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every UART write must match the next expected byte
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && tx_wr) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected tx_wr: got data %0h, nothing expected", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", {24'h0, tx_data}, {24'h0, e[7:0]});
                check("grant", {30'h0, grant}, {30'h0, e[9:8]});
            end
        end
    end

    task automatic refresh();
        src0_empty = (q0.size() == 0);
        src1_empty = (q1.size() == 0);
        src0_rdata = (q0.size() != 0) ? q0[0] : 8'h00;
        src1_rdata = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    // One clock: FIFO pops and UART frame model, then inputs settle 1 after edge
    task automatic tick();
        logic r0, r1, w;
        r0 = src0_rd;
        r1 = src1_rd;
        w  = tx_wr;
        @(posedge clk);
        #1;
        cyc++;
        if (r0 && q0.size() != 0) void'(q0.pop_front());
        if (r1 && q1.size() != 0) void'(q1.pop_front());
        tx_done = 1'b0;
        if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) tx_done = 1'b1;
        end
        if (w) ucnt = 1;
        refresh();
        if (gap_chk && (src0_rd || src1_rd) && last_done >= 0) begin
            check("back-to-back rd after tx_done", cyc - last_done, 2);
            last_done = -1;
        end
        if (tx_done) last_done = cyc;
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        g_enable  = 1'b0;
        g_tx_done = 1'b0;
        baudtick  = 1'b0;
        tx_done   = 1'b0;
        ucnt      = 0;
        q0.delete();
        q1.delete();
        refresh();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_until_idle(input string name, input int max_cyc);
        int k;
        k = 0;
        while (!(!busy && (!enable || (src0_empty && src1_empty))) && k < max_cyc) begin
            tick();
            k++;
        end
        check({name, " completes"}, k < max_cyc, 1);
    endtask

    initial begin
        int k;
        int nrd;
        int nb;
        ord = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                8'h04, 8'h05, 8'h06, 8'h07, 8'h14, 8'h15, 8'h16, 8'h17,
                8'h08, 8'h09, 8'h18, 8'h19};
        enable = 0; g_enable = 0; g_tx_done = 0; baudtick = 0; tx_done = 0;
        refresh();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        // Reset state, before any clock edge
        check("reset tx_wr", tx_wr, 0);
        check("reset busy", busy, 0);
        check("reset grant", grant, 0);
        check("reset cnt0", cnt0, 0);
        check("reset cnt1", cnt1, 0);
        check("reset tx_data", tx_data, 0);
        check("reset rd", {src1_rd, src0_rd}, 0);

        // Single byte
        do_reset();
        q0.push_back(8'hA5);
        refresh();
        exp_q.push_back({2'b01, 8'hA5});
        enable = 1'b1;
        check("single idle rd", src0_rd, 0);
        tick();
        check("single pop rd", src0_rd, 1);
        check("single pop wr", tx_wr, 0);
        check("single pop grant", grant, 2'b01);
        tick();
        check("single wr", tx_wr, 1);
        check("single wr rd", src0_rd, 0);
        k = 0;
        while (!tx_done && k < 20) begin tick(); k++; end
        check("single tx_done seen", tx_done, 1);
        check("single busy at done", busy, 1);
        tick();
        check("single busy after done", busy, 0);
        check("single grant idle", grant, 0);
        check("single cnt0", cnt0, 1);
        check("single cnt1", cnt1, 0);

        // Burst / fairness
        do_reset();
        for (int i = 0; i < 10; i++) begin
            q0.push_back(8'(i));
            q1.push_back(8'(8'h10 + i));
        end
        refresh();
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back({(ord[i][4] ? 2'b10 : 2'b01), ord[i]});
        end
        enable = 1'b1;
        run_until_idle("fairness", 400);
        check("fairness cnt0", cnt0, 10);
        check("fairness cnt1", cnt1, 10);
        check("fairness all written", exp_q.size(), 0);

        // Work-conserving back-to-back on a single source
        do_reset();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'(8'h40 + i));
            exp_q.push_back({2'b01, 8'(8'h40 + i)});
        end
        refresh();
        last_done = -1;
        gap_chk = 1'b1;
        enable = 1'b1;
        run_until_idle("work-conserving", 200);
        gap_chk = 1'b0;
        check("work-conserving cnt0", cnt0, 6);
        check("work-conserving all written", exp_q.size(), 0);

        // Enable dropped during WAIT
        do_reset();
        q0.push_back(8'h31);
        q0.push_back(8'h32);
        refresh();
        exp_q.push_back({2'b01, 8'h31});
        enable = 1'b1;
        k = 0;
        while (!tx_wr && k < 10) begin tick(); k++; end
        check("enable-drop wr seen", tx_wr, 1);
        tick();
        enable = 1'b0;
        nrd = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (src0_rd || src1_rd) nrd++;
        end
        check("enable-drop no further pop", nrd, 0);
        check("enable-drop busy", busy, 0);
        check("enable-drop fifo left", q0.size(), 1);
        check("enable-drop cnt0", cnt0, 1);

        // Reset pulsed during WR
        do_reset();
        q0.push_back(8'h55);
        refresh();
        enable = 1'b1;
        tick();
        tick();
        check("rst-in-wr wr before", tx_wr, 1);
        rst_n = 1'b0;
        #1;
        check("rst-in-wr tx_wr", tx_wr, 0);
        check("rst-in-wr busy", busy, 0);
        check("rst-in-wr cnt0", cnt0, 0);
        check("rst-in-wr grant", grant, 0);
        enable = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("rst-in-wr stays idle", busy, 0);

        // Guard of 3 baud ticks
        do_reset();
        g_enable = 1'b1;
        k = 0;
        while (!g_tx_wr && k < 10) begin tick(); k++; end
        check("guard wr seen", g_tx_wr, 1);
        check("guard tx_data", g_tx_data, 8'h5A);
        baudtick = 1'b1;
        tick();
        baudtick = 1'b0;
        tick();
        g_tx_done = 1'b1;
        baudtick  = 1'b1;
        tick();
        g_tx_done = 1'b0;
        baudtick  = 1'b0;
        check("guard grant", g_grant, 2'b01);
        check("guard busy", g_busy, 1);
        nb = 0;
        k = 0;
        while (!g_src0_rd && k < 40) begin
            baudtick = (k % 3 == 2);
            if (baudtick) nb++;
            tick();
            k++;
        end
        baudtick = 1'b0;
        check("guard next pop seen", g_src0_rd, 1);
        check("guard baudticks", nb, 3);
        check("guard cnt0", g_cnt0, 1);
        check("guard src1 idle", {g_cnt1[15:1], g_cnt1[0] | g_src1_rd}, 0);
        g_enable = 1'b0;

        // Counter wrap on source 1
        do_reset();
        force dut.cnt1 = 16'hFFFF;
        tick();
        release dut.cnt1;
        check("wrap preload", cnt1, 16'hFFFF);
        q1.push_back(8'h77);
        refresh();
        exp_q.push_back({2'b10, 8'h77});
        enable = 1'b1;
        run_until_idle("wrap", 50);
        check("wrap cnt1", cnt1, 0);
        check("wrap cnt0", cnt0, 0);

        tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart2wifi_core_tx_sched.md
# uart2wifi_core_tx_sched

Transmit scheduler that shares the single `uart2wifi_core_uart` transmitter between two byte sources, each a `uart2wifi_core_fifo` instance. Source 0 carries command/response traffic and source 1 carries RX loopback traffic. The block arbitrates round-robin with a per-source burst limit, pops one byte from the winning FIFO and issues a `tx_wr` strobe. It then holds off until the UART reports the frame complete, plus an optional inter-byte guard measured in baud ticks. It sits between the two FIFOs and the UART inside `uart2wifi_core_ip`.

## Interface
- `BURST_MAX`, 4: maximum consecutive bytes granted to one source while the other is non-empty (1..15).
- `GUARD_TICKS`, 0: baud-tick pulses inserted after each `tx_done` before the next pop (0..255).
- `clk` in 1: system clock (50 MHz).
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: scheduler enable; when 0, no new byte is started.
- `baudtick` in 1: one-cycle pulse from the baud generator.
- `src0_empty` in 1: source 0 FIFO empty.
- `src0_rdata` in 8: source 0 FIFO head (first-word fall-through, valid while `!src0_empty`).
- `src0_rd` out 1: source 0 pop strobe.
- `src1_empty`, `src1_rdata`, `src1_rd`: same as source 0, for source 1.
- `tx_wr` out 1: one-cycle write strobe to the UART.
- `tx_data` out 8: byte to the UART, valid when `tx_wr`=1.
- `tx_done` in 1: one-cycle pulse from the UART at the end of the stop bit.
- `grant` out 2: one-hot owner of the byte in flight; 00 when idle.
- `busy` out 1: 1 in any state other than IDLE.
- `cnt0` out 16: bytes popped from source 0.
- `cnt1` out 16: bytes popped from source 1.

## Operation
- States are IDLE, POP, WR, WAIT and GUARD.
- **IDLE:** when `enable`=1 and either source is non-empty, register the selected source and go to POP. Otherwise stay in IDLE.
- **POP:** drive `srcX_rd`=1 combinationally for exactly one cycle. Capture `srcX_rdata` into the `tx_data` register. Increment `cntX`, which wraps from 0xFFFF to 0. Go to WR.
- **WR:** `tx_wr`=1 for one cycle. Go to WAIT.
- **WAIT:** on `tx_done`=1, go to GUARD if `GUARD_TICKS`>0, otherwise go to IDLE.
- **GUARD:** count `baudtick` pulses. When the count reaches `GUARD_TICKS`, go to IDLE and clear the counter.
- `tx_done` is also accepted in the WR cycle and is then treated as if it arrived in WAIT. It is ignored in IDLE, POP and GUARD.
- **Arbitration (evaluated in IDLE):**
  - Keep the current owner if it is non-empty and `burst_cnt` < `BURST_MAX`.
  - Otherwise switch to the other source if it is non-empty.
  - Otherwise stay with the current owner (work-conserving).
  - `burst_cnt` resets to 1 on a switch, increments on a repeat grant and saturates at `BURST_MAX`.
  - On a tie with no history, source 0 wins: `last_owner` resets to source 1.
- **`enable` falling** mid-byte: the byte in progress completes through WAIT and GUARD, then the block parks in IDLE. No further pop occurs and `burst_cnt` is preserved.
- **Reset (any state):**
  - State returns to IDLE.
  - `tx_wr`, `srcX_rd`, `tx_data`, `grant`, `busy`, `cnt0`, `cnt1`, `burst_cnt` and the guard counter all go to 0.
  - `last_owner` is set to 1.
  - A byte already popped is discarded; no re-push.

## Timing
- `srcX_rd` and `tx_wr` are never asserted in the same cycle, and each lasts exactly one cycle.
- Latency from the first IDLE cycle with a non-empty source (and `enable`=1):
  - `srcX_rd` rises 1 cycle later.
  - `tx_wr` rises 2 cycles later.
- `tx_data` is stable from WR until the next POP.
- `grant` is valid from POP through GUARD and is 00 in IDLE.
- Back-to-back with `GUARD_TICKS`=0: the next `srcX_rd` comes 2 cycles after `tx_done`, and `tx_wr` 3 cycles after.
- A `baudtick` in the same cycle as `tx_done` is not counted toward the guard.

## Test plan
- **Single byte:** src0 holds 0xA5, src1 empty, `enable`=1.
  - `src0_rd` is 1 cycle after IDLE detection and `tx_wr` 2 cycles after, with `tx_data`=0xA5 and `grant`=01.
  - `busy` drops 1 cycle after `tx_done`; `cnt0`=1.
- **Burst/fairness:** `BURST_MAX`=4, both FIFOs hold 10 bytes (src0 0x00..0x09, src1 0x10..0x19).
  - `tx_data` order: 00,01,02,03,10,11,12,13,04,05,06,07,14,...
  - `cnt0`=`cnt1`=10 at the end.
- **Work-conserving:** src0 holds 6 bytes, src1 empty → all 6 bytes are sent consecutively with no stall.
- **Guard:** `GUARD_TICKS`=3 → exactly 3 `baudtick` pulses occur between `tx_done` and the next `src0_rd`.
- **Enable drop and reset:**
  - `enable`→0 during WAIT: the byte completes, then there is no further `srcX_rd`.
  - `rst_n` pulsed low during WR: `tx_wr`=0, `busy`=0 and `cnt0`=0 immediately, without waiting for a clock edge.
- **Counter wrap:** preload 65536 pops on src1 → `cnt1` reads 0.
